// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for a shared 1-bit ALU slice: streams operands LSB first,
// recirculates the slice carry and assembles the WIDTH-bit result.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             CarryIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             S1,
  output logic             S0,
  output logic             SliceA,
  output logic             SliceB,
  output logic             SliceCin,
  input  logic             SliceF,
  input  logic             SliceCout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Increment forces a carry of 1, add takes the caller's carry, logic ops have none.
  function automatic logic carry_seed(input logic [1:0] op, input logic cin);
    logic seed;
    case (op)
      2'b00:   seed = 1'b1;
      2'b01:   seed = cin;
      default: seed = 1'b0;
    endcase
    return seed;
  endfunction

  // Next-state, datapath shifting and registered status computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    shf_d    = shf_q;
    result_d = result_q;
    cout_d   = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          op_d    = Op;
          a_d     = OpA;
          b_d     = OpB;
          carry_d = carry_seed(Op, CarryIn);
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        shf_d   = {SliceF, shf_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = op_q[1] ? 1'b0 : SliceCout;
        cnt_d   = cnt_q + CW'(1'b1);
        // Result is only published on the final bit so no partial value is ever visible.
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          result_d = shf_d;
          cout_d   = op_q[1] ? 1'b0 : SliceCout;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CW{1'b0}};
      op_q     <= 2'b00;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      shf_q    <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      shf_q    <= shf_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Slice drive: live only while running so the shared slice sees zeros otherwise.
  always_comb begin
    S1       = 1'b0;
    S0       = 1'b0;
    SliceA   = 1'b0;
    SliceB   = 1'b0;
    SliceCin = 1'b0;
    if (state_q == ST_RUN) begin
      S1       = op_q[1];
      S0       = op_q[0];
      SliceA   = a_q[0];
      SliceB   = b_q[0];
      SliceCin = carry_q;
    end else begin
      S1       = 1'b0;
      S0       = 1'b0;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Result   = result_q;
  assign CarryOut = cout_q;

endmodule
